decimator: RTL and testbench

DECIMATOR -- requirements
Module: decimator

---
 rtl/decimator.sv | 121 ++++++++++++
 tb/tb_decimator.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decimator.sv
// Sample-rate decimator: keeps the phase-0 sample of every DECIM_FACTOR accepted samples.
// Optional macro DECIMATOR_AVG_EN switches to integrate-and-dump averaging of each window.
module decimator #(
    parameter string ARCHITECTURE = "BEHAVIORAL",
    parameter int    DATA_WIDTH   = 32,
    parameter int    DECIM_FACTOR = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  sync,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_sync
);

    localparam int            LOG2N      = $clog2(DECIM_FACTOR);
    localparam int            PW         = (LOG2N > 0) ? LOG2N : 1;
    localparam logic [PW-1:0] LAST_PHASE = PW'(DECIM_FACTOR - 1);
    localparam logic [PW-1:0] SYNC_NEXT  = (DECIM_FACTOR > 1) ? PW'(1) : '0;
    localparam bit            FUNCTIONAL = (ARCHITECTURE == "BEHAVIORAL");

    logic                  accept;
    logic                  start;
    logic [PW-1:0]         phase_q, phase_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_sync_q, out_sync_d;

    assign accept = en & in_valid;
    // A sync sample is always the first sample of a fresh window.
    assign start  = sync | (phase_q == '0);

    always_comb begin
        phase_d = phase_q;
        if (accept) begin
            if (sync) begin
                phase_d = SYNC_NEXT;
            end else if (phase_q == LAST_PHASE) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + PW'(1);
            end
        end
    end

`ifdef DECIMATOR_AVG_EN
    localparam int AW     = DATA_WIDTH + LOG2N;
    localparam bit SINGLE = (DECIM_FACTOR == 1);

    logic                 last;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [AW-1:0] sum;
    logic                 pend_q, pend_d;

    assign last = sync ? SINGLE : (phase_q == LAST_PHASE);
    assign sum  = start ? AW'(signed'(in_data)) : acc_q + AW'(signed'(in_data));

    always_comb begin
        acc_d       = acc_q;
        pend_d      = pend_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_sync_d  = 1'b0;
        if (accept) begin
            acc_d = sum;
            if (last) begin
                pend_d      = 1'b0;
                out_data_d  = sum[AW-1:LOG2N];
                out_valid_d = 1'b1;
                out_sync_d  = sync | pend_q;
            end else if (sync) begin
                pend_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            pend_q <= pend_d;
        end
    end
`else
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        out_sync_d  = 1'b0;
        if (accept && start) begin
            out_data_d  = in_data;
            out_valid_d = 1'b1;
            out_sync_d  = sync;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_sync_q  <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_sync_q  <= out_sync_d;
        end
    end

    // Non-behavioral architectures are placeholders and never present data.
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q & FUNCTIONAL;
    assign out_sync  = out_sync_q & FUNCTIONAL;

endmodule

// File: tb/tb_decimator.sv
// Scoreboard bench for decimator: three instances (N=4, N=2, N=1) share clock and reset.
// Expectations follow DECIMATOR_AVG_EN when the bench is built with that macro.
module tb_decimator;

    typedef struct {
        logic [15:0] d;
        logic        s;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    exp_t        q[3][$];
    logic [15:0] last_d[3];

    logic        en0 = 1'b1, v0 = 1'b0, s0 = 1'b0;
    logic        en1 = 1'b1, v1 = 1'b0, s1 = 1'b0;
    logic        en2 = 1'b1, v2 = 1'b0, s2 = 1'b0;
    logic [15:0] d0 = '0, d1 = '0, d2 = '0;
    logic [15:0] od0, od1, od2;
    logic        ov0, ov1, ov2, os0, os1, os2;

    decimator #(.ARCHITECTURE("BEHAVIORAL"), .DATA_WIDTH(16), .DECIM_FACTOR(4)) u_n4 (
        .clk(clk), .rst_n(rst_n), .en(en0), .sync(s0), .in_data(d0), .in_valid(v0),
        .out_data(od0), .out_valid(ov0), .out_sync(os0));

    decimator #(.ARCHITECTURE("BEHAVIORAL"), .DATA_WIDTH(16), .DECIM_FACTOR(2)) u_n2 (
        .clk(clk), .rst_n(rst_n), .en(en1), .sync(s1), .in_data(d1), .in_valid(v1),
        .out_data(od1), .out_valid(ov1), .out_sync(os1));

    decimator #(.ARCHITECTURE("BEHAVIORAL"), .DATA_WIDTH(16), .DECIM_FACTOR(1)) u_n1 (
        .clk(clk), .rst_n(rst_n), .en(en2), .sync(s2), .in_data(d2), .in_valid(v2),
        .out_data(od2), .out_valid(ov2), .out_sync(os2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_out(input int id, input logic [15:0] d, input logic s);
        exp_t e;
        e.d = d;
        e.s = s;
        e.c = cyc + 1;
        q[id].push_back(e);
    endtask

    // Drives one cycle on DUT id; the other instances see an idle cycle.
    task automatic step(input int id, input logic e, input logic v, input logic s,
                        input logic [15:0] d);
        en0 = 1'b1; en1 = 1'b1; en2 = 1'b1;
        v0 = 1'b0;  v1 = 1'b0;  v2 = 1'b0;
        s0 = 1'b0;  s1 = 1'b0;  s2 = 1'b0;
        case (id)
            0: begin en0 = e; v0 = v; s0 = s; d0 = d; end
            1: begin en1 = e; v1 = v; s1 = s; d1 = d; end
            default: begin en2 = e; v2 = v; s2 = s; d2 = d; end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", nm, got, req);
        end
    endtask

    task automatic mon(input int id, input logic ov, input logic [15:0] od, input logic os);
        exp_t e;
        if (!rst_n) begin
            last_d[id] = '0;
            return;
        end
        if (ov === 1'b1) begin
            total++;
            if (q[id].size() == 0) begin
                bad++;
                $display("FAIL unexpected_out dut%0d got=%0d required=none", id, od);
            end else begin
                e = q[id].pop_front();
                total++;
                if (od !== e.d) begin
                    bad++;
                    $display("FAIL out_data dut%0d got=%0d required=%0d", id, $signed(od), $signed(e.d));
                end
                total++;
                if (os !== e.s) begin
                    bad++;
                    $display("FAIL out_sync dut%0d got=%0b required=%0b", id, os, e.s);
                end
                total++;
                if (cyc != e.c) begin
                    bad++;
                    $display("FAIL latency dut%0d got_cycle=%0d required_cycle=%0d", id, cyc, e.c);
                end
            end
            last_d[id] = od;
        end else begin
            total++;
            if (os !== 1'b0 || ov !== 1'b0) begin
                bad++;
                $display("FAIL idle_flags dut%0d got_valid=%0b got_sync=%0b required=0", id, ov, os);
            end
            total++;
            if (od !== last_d[id]) begin
                bad++;
                $display("FAIL hold dut%0d got=%0d required=%0d", id, od, last_d[id]);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, ov0, od0, os0);
        mon(1, ov1, od1, os1);
        mon(2, ov2, od2, os2);
    end

    initial begin
        logic        vv, ss;
        logic [15:0] dd;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_data_n4", 32'(od0), 32'd0);
        chk("reset_valid_n4", 32'(ov0), 32'd0);
        chk("reset_sync_n4", 32'(os0), 32'd0);
        chk("reset_valid_n1", 32'(ov2), 32'd0);
        rst_n = 1'b1;

        // Continuous ramp on N=4.
        for (int i = 0; i < 12; i++) begin
`ifdef DECIMATOR_AVG_EN
            if (i == 3)  expect_out(0, 16'd1, 1'b0);
            if (i == 7)  expect_out(0, 16'd5, 1'b0);
            if (i == 11) expect_out(0, 16'd9, 1'b0);
`else
            if (i == 0) expect_out(0, 16'd0, 1'b0);
            if (i == 4) expect_out(0, 16'd4, 1'b0);
            if (i == 8) expect_out(0, 16'd8, 1'b0);
`endif
            step(0, 1'b1, 1'b1, 1'b0, 16'(i));
        end

        // Ramp with sync on sample 6.
        for (int i = 0; i < 14; i++) begin
`ifdef DECIMATOR_AVG_EN
            if (i == 3)  expect_out(0, 16'd1, 1'b0);
            if (i == 9)  expect_out(0, 16'd7, 1'b1);
            if (i == 13) expect_out(0, 16'd11, 1'b0);
`else
            if (i == 0)  expect_out(0, 16'd0, 1'b0);
            if (i == 4)  expect_out(0, 16'd4, 1'b0);
            if (i == 6)  expect_out(0, 16'd6, 1'b1);
            if (i == 10) expect_out(0, 16'd10, 1'b0);
`endif
            step(0, 1'b1, 1'b1, i == 6, 16'(i));
        end

        // Signed window, with syncs that must be ignored (in_valid=0, then en=0).
`ifndef DECIMATOR_AVG_EN
        expect_out(0, 16'd10, 1'b0);
`endif
        step(0, 1'b1, 1'b1, 1'b0, 16'd10);
        step(0, 1'b1, 1'b1, 1'b0, 16'd20);
        step(0, 1'b1, 1'b0, 1'b1, 16'd999);
        step(0, 1'b1, 1'b1, 1'b0, 16'd30);
        step(0, 1'b0, 1'b1, 1'b1, 16'd777);
`ifdef DECIMATOR_AVG_EN
        expect_out(0, 16'd25, 1'b0);
`endif
        step(0, 1'b1, 1'b1, 1'b0, 16'd40);
`ifndef DECIMATOR_AVG_EN
        expect_out(0, 16'hFFF8, 1'b0);
`endif
        step(0, 1'b1, 1'b1, 1'b0, 16'hFFF8);
        step(0, 1'b1, 1'b1, 1'b0, 16'hFFF8);
        step(0, 1'b1, 1'b1, 1'b0, 16'hFFF8);
`ifdef DECIMATOR_AVG_EN
        expect_out(0, 16'hFFF8, 1'b0);
`endif
        step(0, 1'b1, 1'b1, 1'b0, 16'hFFF9);

        // N=2: enable low for three cycles mid-window while in_valid stays high.
`ifndef DECIMATOR_AVG_EN
        expect_out(1, 16'd200, 1'b0);
`endif
        step(1, 1'b1, 1'b1, 1'b0, 16'd200);
        step(1, 1'b0, 1'b1, 1'b1, 16'hDEAD);
        step(1, 1'b0, 1'b1, 1'b0, 16'hBEEF);
        step(1, 1'b0, 1'b1, 1'b1, 16'h1234);
`ifdef DECIMATOR_AVG_EN
        expect_out(1, 16'd200, 1'b0);
`endif
        step(1, 1'b1, 1'b1, 1'b0, 16'd201);
`ifndef DECIMATOR_AVG_EN
        expect_out(1, 16'd202, 1'b0);
`endif
        step(1, 1'b1, 1'b1, 1'b0, 16'd202);
`ifdef DECIMATOR_AVG_EN
        expect_out(1, 16'd202, 1'b0);
`endif
        step(1, 1'b1, 1'b1, 1'b0, 16'd203);

        // Reset in the middle of a sync-started window on N=4.
`ifndef DECIMATOR_AVG_EN
        expect_out(0, 16'd50, 1'b1);
`endif
        step(0, 1'b1, 1'b1, 1'b1, 16'd50);
        step(0, 1'b1, 1'b1, 1'b0, 16'd51);
        step(0, 1'b1, 1'b1, 1'b0, 16'd52);
        rst_n = 1'b0;
        #1;
        chk("async_reset_data_n4", 32'(od0), 32'd0);
        chk("async_reset_valid_n4", 32'(ov0), 32'd0);
        chk("async_reset_sync_n4", 32'(os0), 32'd0);
        chk("async_reset_data_n2", 32'(od1), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 60; i < 65; i++) begin
`ifdef DECIMATOR_AVG_EN
            if (i == 63) expect_out(0, 16'd61, 1'b0);
`else
            if (i == 60 || i == 64) expect_out(0, 16'(i), 1'b0);
`endif
            step(0, 1'b1, 1'b1, 1'b0, 16'(i));
        end

        // N=1 pass-through with in_valid gaps; sync at i=3 arrives without in_valid.
        for (int i = 0; i < 24; i++) begin
            vv = (i == 7) ? 1'b1 : ((i == 3) ? 1'b0 : 1'($urandom_range(0, 1)));
            ss = (i == 7) || (i == 3);
            dd = 16'($urandom);
            if (vv) expect_out(2, dd, ss);
            step(2, 1'b1, vv, ss, dd);
        end

        step(0, 1'b1, 1'b0, 1'b0, 16'd0);
        step(0, 1'b1, 1'b0, 1'b0, 16'd0);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (q[k].size() != 0) begin
                bad++;
                $display("FAIL leftover dut%0d got=%0d required=0", k, q[k].size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
